// File: rtl/lsu_datamemory.sv
// Load/store unit: turns one load/store request into one or two word-aligned
// memory beats with byte masks, and steers/extends read data back to the pipeline.
module lsu_datamemory #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned ADDR_W         = 32,
    parameter bit          MISALIGN_SPLIT = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                resp_valid,
    output logic [XLEN-1:0]     resp_data,
    output logic                resp_err,
    output logic                mem_req,
    input  logic                mem_gnt,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_a,
    output logic [XLEN-1:0]     mem_wd,
    output logic [XLEN/8-1:0]   mem_wmask,
    input  logic                mem_rvalid,
    input  logic [XLEN-1:0]     mem_rd
);

    localparam int unsigned B     = XLEN / 8;
    localparam int unsigned MW    = 2 * B;
    localparam int unsigned OFF_W = $clog2(B);
    localparam int unsigned IDX_W = $clog2(XLEN);
    localparam int unsigned SH_W  = $clog2(XLEN) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_RESP, S_ERR
    } state_t;

    state_t            state;
    logic              we_q;
    logic [1:0]        size_q;
    logic              sgn_q;
    logic [OFF_W-1:0]  off_q;
    logic              cross_q;
    logic [B-1:0]      mask1_q;
    logic [XLEN-1:0]   rd0_q;

    logic [1:0]        size_n;
    logic [OFF_W-1:0]  off_n;
    logic [3:0]        nbytes_n;
    logic              cross_n;
    logic [MW-1:0]     lanemask_n;
    logic [XLEN-1:0]   wd_rot_n;
    logic [OFF_W+2:0]  wsh_n;

    logic [2*XLEN-1:0] rd_pair;
    logic [XLEN-1:0]   rd_low;
    logic [XLEN-1:0]   keep;
    logic [SH_W-1:0]   keep_sh;
    logic [IDX_W-1:0]  msb_idx;
    logic [XLEN-1:0]   load_val;

    // Dword requests collapse to word on a 32-bit datapath.
    always_comb begin
        size_n = req_size;
        if (XLEN == 32 && req_size == 2'd3) size_n = 2'd2;
    end

    // Request decode: lane offset, word crossing, 2B-wide lane mask, rotated store data.
    assign off_n      = req_addr[OFF_W-1:0];
    assign nbytes_n   = 4'd1 << size_n;
    assign cross_n    = (5'(off_n) + 5'(nbytes_n)) > 5'(B);
    assign lanemask_n = MW'((16'd1 << nbytes_n) - 16'd1) << off_n;
    assign wsh_n      = {off_n, 3'b000};
    assign wd_rot_n   = (req_wdata << wsh_n) | (req_wdata >> (XLEN - 32'(wsh_n)));

    // Read steering: shift the beat pair down by the offset, keep n bytes, extend.
    always_comb begin
        rd_pair  = (state == S_WAIT1) ? {mem_rd, rd0_q} : {{XLEN{1'b0}}, mem_rd};
        rd_low   = XLEN'(rd_pair >> {off_q, 3'b000});
        keep_sh  = SH_W'(XLEN - (32'd8 << size_q));
        keep     = {XLEN{1'b1}} >> keep_sh;
        msb_idx  = IDX_W'((32'd8 << size_q) - 32'd1);
        load_val = (rd_low & keep) | ((sgn_q && rd_low[msb_idx]) ? ~keep : {XLEN{1'b0}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_a      <= '0;
            mem_wd     <= '0;
            mem_wmask  <= '0;
            we_q       <= 1'b0;
            size_q     <= 2'd0;
            sgn_q      <= 1'b0;
            off_q      <= '0;
            cross_q    <= 1'b0;
            mask1_q    <= '0;
            rd0_q      <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        we_q      <= req_we;
                        size_q    <= size_n;
                        sgn_q     <= req_signed;
                        off_q     <= off_n;
                        cross_q   <= cross_n;
                        mask1_q   <= lanemask_n[MW-1:B];
                        if (cross_n && !MISALIGN_SPLIT) begin
                            state      <= S_ERR;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_data  <= '0;
                        end else begin
                            state     <= S_REQ0;
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_a     <= {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                            mem_wd    <= wd_rot_n;
                            mem_wmask <= req_we ? lanemask_n[B-1:0] : '0;
                        end
                    end
                end
                S_REQ0: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= S_WAIT0;
                    end
                end
                S_WAIT0: begin
                    if (mem_rvalid) begin
                        rd0_q <= mem_rd;
                        if (cross_q) begin
                            state     <= S_REQ1;
                            mem_req   <= 1'b1;
                            mem_a     <= mem_a + ADDR_W'(B);
                            mem_wmask <= we_q ? mask1_q : '0;
                        end else begin
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_data  <= we_q ? '0 : load_val;
                        end
                    end
                end
                S_REQ1: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= S_WAIT1;
                    end
                end
                S_WAIT1: begin
                    if (mem_rvalid) begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_data  <= we_q ? '0 : load_val;
                    end
                end
                S_RESP, S_ERR: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_datamemory.sv
// Directed bench for lsu_datamemory (XLEN=32): a split-mode unit with a zero-wait
// memory model, plus an error-mode unit for rejected misaligned accesses.
module tb_lsu_datamemory;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, e_req_valid;
    logic        req_ready, e_req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, e_resp_valid;
    logic [31:0] resp_data, e_resp_data;
    logic        resp_err, e_resp_err;
    logic        mem_req, e_mem_req;
    logic        mem_gnt, e_mem_gnt;
    logic        mem_we, e_mem_we;
    logic [31:0] mem_a, e_mem_a;
    logic [31:0] mem_wd, e_mem_wd;
    logic [3:0]  mem_wmask, e_mem_wmask;
    logic        mem_rvalid, e_mem_rvalid;
    logic [31:0] mem_rd;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lsu_datamemory #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_err(resp_err), .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_wmask(mem_wmask),
        .mem_rvalid(mem_rvalid), .mem_rd(mem_rd)
    );

    lsu_datamemory #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(1'b0)) u_err (
        .clk(clk), .rst_n(rst_n),
        .req_valid(e_req_valid), .req_ready(e_req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(e_resp_valid), .resp_data(e_resp_data),
        .resp_err(e_resp_err), .mem_req(e_mem_req), .mem_gnt(e_mem_gnt), .mem_we(e_mem_we),
        .mem_a(e_mem_a), .mem_wd(e_mem_wd), .mem_wmask(e_mem_wmask),
        .mem_rvalid(e_mem_rvalid), .mem_rd(mem_rd)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request and plays a zero-wait memory; returns what the DUT showed.
    task automatic run_access(
        input  logic        we, input logic [1:0] size, input logic sgn,
        input  logic [31:0] addr, input logic [31:0] wdata,
        input  logic [31:0] rd0, input logic [31:0] rd1,
        output int lat, output int beats,
        output logic [31:0] a0, output logic [31:0] a1,
        output logic [3:0] m0, output logic [3:0] m1,
        output logic [31:0] wd0, output logic [31:0] wd1,
        output logic [31:0] data, output logic err,
        output logic rdy_busy, output logic rdy_after);
        bit pend = 0;
        bit done = 0;
        beats = 0; a0 = '0; a1 = '0; m0 = '0; m1 = '0; wd0 = '0; wd1 = '0;
        data = 'x; err = 1'bx;
        req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        lat = 1;
        rdy_busy = req_ready;
        while (!done && lat < 20) begin
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            if (resp_valid) begin
                data = resp_data;
                err  = resp_err;
                done = 1;
            end else begin
                if (pend) begin
                    mem_rvalid = 1'b1;
                    mem_rd = (beats == 1) ? rd0 : rd1;
                    pend = 0;
                end else if (mem_req) begin
                    if (beats == 0) begin a0 = mem_a; m0 = mem_wmask; wd0 = mem_wd; end
                    else begin a1 = mem_a; m1 = mem_wmask; wd1 = mem_wd; end
                    beats++;
                    mem_gnt = 1'b1;
                    pend = 1;
                end
                step();
                lat++;
            end
        end
        if (!done) lat = -1;
        step();
        rdy_after = req_ready;
    endtask

    task automatic test_reset();
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
        n_tests++; if ({mem_req, mem_we, resp_valid, resp_err} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got=%b exp=0000", {mem_req, mem_we, resp_valid, resp_err}); end
        n_tests++; if ({mem_a, mem_wd, mem_wmask, resp_data} !== 100'h0) begin n_fail++; $display("FAIL reset_buses a=%h wd=%h m=%h d=%h exp=0", mem_a, mem_wd, mem_wmask, resp_data); end
        n_tests++; if (e_req_ready !== 1'b1 || e_mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_errunit ready=%b mem_req=%b exp=1/0", e_req_ready, e_mem_req); end
    endtask

    task automatic test_aligned_load();
        int lat, beats; logic [31:0] a0, a1, wd0, wd1, data; logic [3:0] m0, m1; logic err, rb, ra;
        run_access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0,
                   lat, beats, a0, a1, m0, m1, wd0, wd1, data, err, rb, ra);
        n_tests++; if (a0 !== 32'h100 || m0 !== 4'h0) begin n_fail++; $display("FAIL lw_beat a=%h m=%h exp=100/0", a0, m0); end
        n_tests++; if (lat !== 3 || beats !== 1) begin n_fail++; $display("FAIL lw_latency lat=%0d beats=%0d exp=3/1", lat, beats); end
        n_tests++; if (data !== 32'hDEADBEEF || err !== 1'b0) begin n_fail++; $display("FAIL lw_data got=%h err=%b exp=deadbeef/0", data, err); end
        n_tests++; if (rb !== 1'b0 || ra !== 1'b1) begin n_fail++; $display("FAIL lw_ready busy=%b after=%b exp=0/1", rb, ra); end
    endtask

    task automatic test_byte_load();
        int lat, beats; logic [31:0] a0, a1, wd0, wd1, data; logic [3:0] m0, m1; logic err, rb, ra;
        run_access(1'b0, 2'd0, 1'b1, 32'h207, 32'h0, 32'h80123456, 32'h0,
                   lat, beats, a0, a1, m0, m1, wd0, wd1, data, err, rb, ra);
        n_tests++; if (a0 !== 32'h204) begin n_fail++; $display("FAIL lb_addr got=%h exp=00000204", a0); end
        n_tests++; if (data !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_signed got=%h exp=ffffff80", data); end
        run_access(1'b0, 2'd0, 1'b0, 32'h207, 32'h0, 32'h80123456, 32'h0,
                   lat, beats, a0, a1, m0, m1, wd0, wd1, data, err, rb, ra);
        n_tests++; if (data !== 32'h00000080 || lat !== 3) begin n_fail++; $display("FAIL lbu_data got=%h lat=%0d exp=00000080/3", data, lat); end
    endtask

    task automatic test_split_store();
        int lat, beats; logic [31:0] a0, a1, wd0, wd1, data; logic [3:0] m0, m1; logic err, rb, ra;
        run_access(1'b1, 2'd1, 1'b0, 32'h103, 32'h0000BEEF, 32'h0, 32'h0,
                   lat, beats, a0, a1, m0, m1, wd0, wd1, data, err, rb, ra);
        n_tests++; if (a0 !== 32'h100 || m0 !== 4'b1000 || wd0 !== 32'hEF0000BE) begin n_fail++; $display("FAIL sh_beat0 a=%h m=%b wd=%h exp=100/1000/ef0000be", a0, m0, wd0); end
        n_tests++; if (a1 !== 32'h104 || m1 !== 4'b0001 || wd1 !== 32'hEF0000BE) begin n_fail++; $display("FAIL sh_beat1 a=%h m=%b wd=%h exp=104/0001/ef0000be", a1, m1, wd1); end
        n_tests++; if (lat !== 5 || beats !== 2) begin n_fail++; $display("FAIL sh_latency lat=%0d beats=%0d exp=5/2", lat, beats); end
        n_tests++; if (data !== 32'h0 || err !== 1'b0) begin n_fail++; $display("FAIL sh_resp data=%h err=%b exp=0/0", data, err); end
    endtask

    task automatic test_split_load();
        int lat, beats; logic [31:0] a0, a1, wd0, wd1, data; logic [3:0] m0, m1; logic err, rb, ra;
        run_access(1'b0, 2'd1, 1'b1, 32'h103, 32'h0, 32'hAA112233, 32'h445566BB,
                   lat, beats, a0, a1, m0, m1, wd0, wd1, data, err, rb, ra);
        n_tests++; if (data !== 32'hFFFFBBAA) begin n_fail++; $display("FAIL lh_split_data got=%h exp=ffffbbaa", data); end
        n_tests++; if (lat !== 5 || m0 !== 4'h0 || m1 !== 4'h0 || a1 !== 32'h104) begin n_fail++; $display("FAIL lh_split_beats lat=%0d m0=%h m1=%h a1=%h exp=5/0/0/104", lat, m0, m1, a1); end
    endtask

    task automatic test_back_to_back();
        int lat, beats; logic [31:0] a0, a1, wd0, wd1, data; logic [3:0] m0, m1; logic err, rb, ra;
        run_access(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 32'hBEEF1234, 32'h0,
                   lat, beats, a0, a1, m0, m1, wd0, wd1, data, err, rb, ra);
        n_tests++; if (data !== 32'h0000BEEF || beats !== 1 || lat !== 3) begin n_fail++; $display("FAIL lhu_upper data=%h beats=%0d lat=%0d exp=0000beef/1/3", data, beats, lat); end
        run_access(1'b1, 2'd2, 1'b0, 32'h10C, 32'h12345678, 32'h0, 32'h0,
                   lat, beats, a0, a1, m0, m1, wd0, wd1, data, err, rb, ra);
        n_tests++; if (a0 !== 32'h10C || m0 !== 4'hF || wd0 !== 32'h12345678) begin n_fail++; $display("FAIL sw_beat a=%h m=%h wd=%h exp=10c/f/12345678", a0, m0, wd0); end
        run_access(1'b0, 2'd3, 1'b1, 32'h200, 32'h0, 32'h89ABCDEF, 32'h0,
                   lat, beats, a0, a1, m0, m1, wd0, wd1, data, err, rb, ra);
        n_tests++; if (data !== 32'h89ABCDEF || beats !== 1 || lat !== 3) begin n_fail++; $display("FAIL dword_as_word data=%h beats=%0d lat=%0d exp=89abcdef/1/3", data, beats, lat); end
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h500; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_async_memreq got=%b exp=0", mem_req); end
        step();
        rst_n = 1'b1;
        req_addr = 32'h400; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        #2 rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rd = 32'hCAFEF00D;
        step();
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (resp_valid) seen = 1;
            step();
        end
        n_tests++; if (seen) begin n_fail++; $display("FAIL rst_no_resp got=1 exp=0"); end
        n_tests++; if (req_ready !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_idle ready=%b mem_req=%b exp=1/0", req_ready, mem_req); end
        n_tests++; if ({mem_a, mem_wd, mem_wmask, resp_data, mem_we, resp_err} !== 102'h0) begin n_fail++; $display("FAIL rst_outputs a=%h wd=%h m=%h d=%h exp=0", mem_a, mem_wd, mem_wmask, resp_data); end
    endtask

    task automatic test_stall();
        bit unstable = 0;
        req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0; req_addr = 32'h301; req_wdata = 32'h000000A5;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        n_tests++; if (mem_a !== 32'h300 || mem_wd !== 32'h0000A500 || mem_wmask !== 4'b0010 || mem_we !== 1'b1) begin n_fail++; $display("FAIL sb_fields a=%h wd=%h m=%b we=%b exp=300/0000a500/0010/1", mem_a, mem_wd, mem_wmask, mem_we); end
        for (int i = 0; i < 3; i++) begin
            step();
            if (mem_req !== 1'b1 || mem_a !== 32'h300 || mem_wd !== 32'h0000A500 || mem_wmask !== 4'b0010) unstable = 1;
        end
        n_tests++; if (unstable) begin n_fail++; $display("FAIL stall_hold got=changed exp=stable a=%h wd=%h m=%b", mem_a, mem_wd, mem_wmask); end
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1; mem_rd = 32'hFFFFFFFF;
        step();
        mem_rvalid = 1'b0;
        n_tests++; if (resp_valid !== 1'b1 || resp_data !== 32'h0) begin n_fail++; $display("FAIL stall_resp valid=%b data=%h exp=1/0", resp_valid, resp_data); end
        step();
    endtask

    task automatic test_error();
        req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h102;
        e_req_valid = 1'b1;
        step();
        e_req_valid = 1'b0;
        n_tests++; if (e_resp_valid !== 1'b1 || e_resp_err !== 1'b1) begin n_fail++; $display("FAIL err_resp valid=%b err=%b exp=1/1", e_resp_valid, e_resp_err); end
        n_tests++; if (e_mem_req !== 1'b0 || e_req_ready !== 1'b0) begin n_fail++; $display("FAIL err_t1 mem_req=%b ready=%b exp=0/0", e_mem_req, e_req_ready); end
        step();
        n_tests++; if (e_req_ready !== 1'b1 || e_resp_valid !== 1'b0 || e_mem_req !== 1'b0) begin n_fail++; $display("FAIL err_t2 ready=%b valid=%b mem_req=%b exp=1/0/0", e_req_ready, e_resp_valid, e_mem_req); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; e_req_valid = 1'b0;
        req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rd = '0;
        e_mem_gnt = 1'b0; e_mem_rvalid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        test_reset();
        test_aligned_load();
        test_byte_load();
        test_split_store();
        test_split_load();
        test_back_to_back();
        test_reset_mid();
        test_stall();
        test_error();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
